seq_ctrl_unit: RTL and testbench

//  Parametrised, synthesisable fetch/decode/execute sequencer for the processor datapath (inst_reg, registers, alu).

---
 rtl/seq_ctrl_if.sv | 32 +++
 rtl/seq_ctrl_unit.sv | 212 +++++++++++++++++++++
 tb/tb_seq_ctrl_unit.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_ctrl_if.sv
// Bus bundle between the sequencer and its datapath: instruction memory,
// register file and ALU. The sequencer is the master.
interface seq_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 8,
    parameter int unsigned REG_AW = 3
);
    logic [PC_W-1:0]   imem_addr;
    logic              imem_rd;
    logic [15:0]       imem_data;
    logic [REG_AW-1:0] rf_addr;
    logic              rf_rd;
    logic              rf_wr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;
    logic              alu_cy;
    logic              alu_zero;

    modport master (
        output imem_addr, imem_rd, rf_addr, rf_rd, rf_wr, rf_wdata, alu_op, alu_a, alu_b,
        input  imem_data, rf_rdata, alu_y, alu_cy, alu_zero
    );

    modport slave (
        input  imem_addr, imem_rd, rf_addr, rf_rd, rf_wr, rf_wdata, alu_op, alu_a, alu_b,
        output imem_data, rf_rdata, alu_y, alu_cy, alu_zero
    );
endinterface

// File: rtl/seq_ctrl_unit.sv
// Fetch/decode/execute sequencer: walks each 16-bit instruction through operand
// reads, ALU execution, result and flag write-back, and jump resolution.
module seq_ctrl_unit #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PC_W      = 8,
    parameter int unsigned REG_AW    = 3,
    parameter int unsigned FLAG_ADDR = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    seq_ctrl_if.master      bus,
    output logic            busy,
    output logic            halted,
    output logic            instr_done,
    output logic [PC_W-1:0] pc
);
    // Opcodes 6/A/B carry SHL/INC/DEC; the rest follow the ALU encoding.
    localparam logic [3:0] OpAdd = 4'h0, OpSub = 4'h1, OpAnd = 4'h2, OpOr  = 4'h3;
    localparam logic [3:0] OpXor = 4'h4, OpInv = 4'h5, OpShl = 4'h6, OpMov = 4'h7;
    localparam logic [3:0] OpLdi = 4'h8, OpJz  = 4'h9, OpInc = 4'hA, OpDec = 4'hB;
    localparam logic [3:0] OpHlt = 4'hC, OpJc  = 4'hD, OpJnz = 4'hE, OpJmp = 4'hF;

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StRdA, StRdB, StExec, StWb, StWbf, StCond, StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, wdata_q, wdata_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic              cy_q, cy_d, zero_q, zero_d;

    logic [3:0]        op;
    logic [REG_AW-1:0] dst_addr, sa_addr, sb_addr, flag_addr;
    logic [2:0]        dec_alu_op;
    logic              a_from_dst, is_unary;
    logic [REG_AW-1:0] rf_addr;
    logic              rf_rd, rf_wr, imem_rd, taken;
    logic              unused_ir;

    assign op         = ir_q[15:12];
    assign dst_addr   = REG_AW'(ir_q[9:8]);
    assign sa_addr    = REG_AW'(ir_q[5:4]);
    assign sb_addr    = REG_AW'(ir_q[1:0]);
    assign flag_addr  = REG_AW'(FLAG_ADDR);
    assign a_from_dst = (op == OpShl) || (op == OpInc) || (op == OpDec);
    assign is_unary   = (op == OpInv) || (op == OpInc) || (op == OpDec);
    assign unused_ir  = ^ir_q[11:10];

    always_comb begin
        dec_alu_op = 3'b000;
        case (op)
            OpAdd, OpSub, OpAnd, OpOr, OpXor, OpInv: dec_alu_op = op[2:0];
            OpShl:                                   dec_alu_op = 3'b111;
            OpDec:                                   dec_alu_op = 3'b001;
            default:                                 dec_alu_op = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            ir_q     <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            wdata_q  <= '0;
            alu_op_q <= 3'b000;
            cy_q     <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            wdata_q  <= wdata_d;
            alu_op_q <= alu_op_d;
            cy_q     <= cy_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        wdata_d    = wdata_q;
        alu_op_d   = alu_op_q;
        cy_d       = cy_q;
        zero_d     = zero_q;
        imem_rd    = 1'b0;
        rf_rd      = 1'b0;
        rf_wr      = 1'b0;
        rf_addr    = dst_addr;
        instr_done = 1'b0;
        taken      = 1'b0;
        unique case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                imem_rd = 1'b1;
                ir_d    = bus.imem_data;
                state_d = StDecode;
            end
            StDecode: begin
                pc_d     = pc_q + PC_W'(1);
                alu_op_d = dec_alu_op;
                case (op)
                    OpJmp: begin
                        pc_d       = PC_W'(ir_q[7:0]);
                        instr_done = 1'b1;
                        state_d    = StFetch;
                    end
                    OpHlt: begin
                        instr_done = 1'b1;
                        state_d    = StHalt;
                    end
                    OpLdi: begin
                        wdata_d = DATA_W'(ir_q[7:0]);
                        state_d = StWb;
                    end
                    OpJz, OpJc, OpJnz: state_d = StCond;
                    default:           state_d = StRdA;
                endcase
            end
            StRdA: begin
                rf_rd   = 1'b1;
                rf_addr = a_from_dst ? dst_addr : sa_addr;
                alu_a_d = bus.rf_rdata;
                wdata_d = bus.rf_rdata;
                if (op == OpMov) begin
                    state_d = StWb;
                end else if (is_unary) begin
                    alu_b_d = (op == OpInv) ? '0 : DATA_W'(1);
                    state_d = StExec;
                end else begin
                    state_d = StRdB;
                end
            end
            StRdB: begin
                rf_rd   = 1'b1;
                rf_addr = (op == OpShl) ? sa_addr : sb_addr;
                alu_b_d = bus.rf_rdata;
                state_d = StExec;
            end
            StExec: begin
                wdata_d = bus.alu_y;
                cy_d    = bus.alu_cy;
                zero_d  = bus.alu_zero;
                state_d = StWb;
            end
            StWb: begin
                rf_wr = 1'b1;
                if (op == OpMov || op == OpLdi) begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end else begin
                    wdata_d = {cy_q, zero_q, {(DATA_W-2){1'b0}}};
                    state_d = StWbf;
                end
            end
            StWbf: begin
                rf_wr      = 1'b1;
                rf_addr    = flag_addr;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StCond: begin
                rf_rd = 1'b1;
                case (op)
                    OpJz: begin
                        rf_addr = flag_addr;
                        taken   = bus.rf_rdata[DATA_W-2];
                    end
                    OpJc: begin
                        rf_addr = flag_addr;
                        taken   = bus.rf_rdata[DATA_W-1];
                    end
                    default: taken = |bus.rf_rdata;
                endcase
                if (taken) pc_d = PC_W'(ir_q[7:0]);
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = StIdle;
        endcase
    end

    // A write cut short by reset must not reach the register file.
    assign bus.rf_wr     = rf_wr & rst_n;
    assign bus.rf_rd     = rf_rd;
    assign bus.rf_addr   = rf_addr;
    assign bus.rf_wdata  = wdata_q;
    assign bus.imem_rd   = imem_rd;
    assign bus.imem_addr = pc_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;

    assign pc     = pc_q;
    assign busy   = (state_q != StIdle) && (state_q != StHalt);
    assign halted = (state_q == StHalt);
endmodule

// File: tb/tb_seq_ctrl_unit.sv
// Bench for seq_ctrl_unit: memory/register-file/ALU environment, an ISA-level
// reference that predicts register writes and retirements, and negedge monitors.
module tb_seq_ctrl_unit;
    localparam logic [3:0] OpAdd = 4'h0, OpSub = 4'h1, OpInv = 4'h5, OpShl = 4'h6;
    localparam logic [3:0] OpMov = 4'h7, OpLdi = 4'h8, OpJz  = 4'h9, OpInc = 4'hA;
    localparam logic [3:0] OpDec = 4'hB, OpHlt = 4'hC, OpJc  = 4'hD, OpJnz = 4'hE;
    localparam logic [3:0] OpJmp = 4'hF;

    typedef struct { logic [2:0] addr; logic [7:0] data; } wr_t;
    typedef struct { logic [7:0] addr; int cyc; } ret_t;

    logic       clk = 1'b0;
    logic       rst_n, start, busy, halted, instr_done;
    logic [7:0] pc;
    logic [15:0] imem [256];
    logic [7:0] rf [8] = '{default: 8'h00};
    logic [7:0] m_rf [8];
    wr_t        exp_wr[$];
    ret_t       exp_ret[$];
    int         n_tests = 0, n_fail = 0;
    int         done_cnt = 0, wr_cnt = 0, conflict_cnt = 0, m_n;
    bit         m_halt;

    always #5 clk = ~clk;

    seq_ctrl_if #(.DATA_W(8), .PC_W(8), .REG_AW(3)) bus ();

    seq_ctrl_unit #(.DATA_W(8), .PC_W(8), .REG_AW(3), .FLAG_ADDR(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .busy(busy), .halted(halted), .instr_done(instr_done), .pc(pc)
    );

    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd7:    return {1'b0, a} << b[2:0];
            default: return {1'b0, a};
        endcase
    endfunction

    assign bus.imem_data = imem[bus.imem_addr];
    assign bus.rf_rdata  = rf[bus.rf_addr];
    assign {bus.alu_cy, bus.alu_y} = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
    assign bus.alu_zero  = (bus.alu_y == 8'h00);

    always @(posedge clk) if (bus.rf_wr) rf[bus.rf_addr] <= bus.rf_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] d, s1, s2);
        return {op, 2'b00, d, 2'b00, s1, 2'b00, s2};
    endfunction

    function automatic logic [15:0] encj(input logic [3:0] op, input logic [1:0] d,
                                         input logic [7:0] imm);
        return {op, 2'b00, d, imm};
    endfunction

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) imem[i] = enc(OpHlt, 2'd0, 2'd0, 2'd0);
    endtask

    // Instruction-level interpreter: architectural effect and latency of each op.
    task automatic model_run(input int max_instr);
        logic [7:0] p, nxt, a, b, y;
        logic [15:0] w;
        logic [3:0] op;
        logic [1:0] d, s1, s2;
        logic [2:0] aop;
        logic [8:0] r;
        int cyc;
        bit alu;
        m_n = 0; m_halt = 0; p = 8'h00;
        while (!m_halt && m_n < max_instr) begin
            w = imem[p]; op = w[15:12]; d = w[9:8]; s1 = w[5:4]; s2 = w[1:0];
            nxt = p + 8'd1; alu = 1'b0; a = 8'h00; b = 8'h00; aop = 3'd0; cyc = 0;
            case (op)
                4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
                    alu = 1'b1; a = m_rf[s1]; b = m_rf[s2]; aop = op[2:0]; cyc = 7;
                end
                OpShl: begin alu = 1'b1; a = m_rf[d]; b = m_rf[s1]; aop = 3'd7; cyc = 7; end
                OpInv: begin alu = 1'b1; a = m_rf[s1]; b = 8'h00; aop = 3'd5; cyc = 6; end
                OpInc: begin alu = 1'b1; a = m_rf[d]; b = 8'h01; aop = 3'd0; cyc = 6; end
                OpDec: begin alu = 1'b1; a = m_rf[d]; b = 8'h01; aop = 3'd1; cyc = 6; end
                OpMov: begin
                    m_rf[d] = m_rf[s1]; exp_wr.push_back('{addr: {1'b0, d}, data: m_rf[s1]});
                    cyc = 4;
                end
                OpLdi: begin
                    m_rf[d] = w[7:0]; exp_wr.push_back('{addr: {1'b0, d}, data: w[7:0]});
                    cyc = 3;
                end
                OpJz:  begin if (m_rf[7][6]) nxt = w[7:0]; cyc = 3; end
                OpJc:  begin if (m_rf[7][7]) nxt = w[7:0]; cyc = 3; end
                OpJnz: begin if (m_rf[d] != 8'h00) nxt = w[7:0]; cyc = 3; end
                OpJmp: begin nxt = w[7:0]; cyc = 2; end
                default: begin m_halt = 1'b1; cyc = 2; end
            endcase
            if (alu) begin
                r = alu_f(aop, a, b); y = r[7:0];
                m_rf[d] = y;
                m_rf[7] = {r[8], y == 8'h00, 6'b0};
                exp_wr.push_back('{addr: {1'b0, d}, data: y});
                exp_wr.push_back('{addr: 3'd7, data: m_rf[7]});
            end
            exp_ret.push_back('{addr: p, cyc: cyc});
            p = nxt; m_n++;
        end
    endtask

    initial begin : wr_monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.rf_rd && bus.rf_wr) conflict_cnt++;
            if (bus.rf_wr) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                             bus.rf_addr, bus.rf_wdata);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(bus.rf_addr), 32'(e.addr));
                    check("wr_data", 32'(bus.rf_wdata), 32'(e.data));
                end
            end
        end
    end

    initial begin : ret_monitor
        ret_t e;
        int cyc_cnt = 0;
        logic [7:0] cur = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.imem_rd) begin cyc_cnt = 1; cur = bus.imem_addr; end
            else if (busy) cyc_cnt++;
            if (instr_done) begin
                done_cnt++;
                if (exp_ret.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_retire: got addr %0h expected none", cur);
                end else begin
                    e = exp_ret.pop_front();
                    check("retire_addr", 32'(cur), 32'(e.addr));
                    check("retire_cycles", 32'(cyc_cnt), 32'(e.cyc));
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("start_fetch_rd", 32'(bus.imem_rd), 32'd1);
        check("start_fetch_addr", 32'(bus.imem_addr), 32'd0);
        check("start_halted_low", 32'(halted), 32'd0);
    endtask

    task automatic wait_retire(input int base, input int n, output int budget);
        budget = 10 * n + 20;
        while (done_cnt - base < n && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        check("retire_count", 32'(done_cnt - base), 32'(n));
    endtask

    task automatic end_checks();
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("ret_queue_empty", 32'(exp_ret.size()), 32'd0);
        exp_wr.delete(); exp_ret.delete();
        foreach (m_rf[r]) if (r < 4 || r == 7) check($sformatf("rf_r%0d", r), 32'(rf[r]), 32'(m_rf[r]));
    endtask

    task automatic run_prog(input int max_instr, input bit poke);
        int base, budget;
        model_run(max_instr);
        base = done_cnt;
        pulse_start();
        if (poke) begin
            @(negedge clk);
            if (busy) begin start = 1'b1; @(posedge clk); #1 start = 1'b0; end
        end
        wait_retire(base, m_n, budget);
        if (m_halt && budget > 0) begin
            @(posedge clk); @(negedge clk);
            check("halted_high", 32'(halted), 32'd1);
            check("busy_low_halt", 32'(busy), 32'd0);
        end else begin
            @(posedge clk); #1 rst_n = 1'b0;
            @(posedge clk); #1 rst_n = 1'b1;
            @(negedge clk);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_pc", 32'(pc), 32'd0);
        end
        end_checks();
    endtask

    initial begin : main
        int base, budget, wbase;
        logic [3:0] op;
        rst_n = 1'b0; start = 1'b0;
        foreach (m_rf[i]) m_rf[i] = 8'h00;
        fill_halt();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_done", 32'(instr_done), 32'd0);
        check("reset_imem_rd", 32'(bus.imem_rd), 32'd0);
        check("reset_rf_rd", 32'(bus.rf_rd), 32'd0);
        check("reset_rf_wr", 32'(bus.rf_wr), 32'd0);
        check("reset_pc", 32'(pc), 32'd0);
        check("reset_alu_op", 32'(bus.alu_op), 32'd0);
        check("reset_alu_a", 32'(bus.alu_a), 32'd0);
        check("reset_alu_b", 32'(bus.alu_b), 32'd0);
        check("reset_wdata", 32'(bus.rf_wdata), 32'd0);
        rst_n = 1'b1;

        // LDI/LDI/ADD/HLT, with a start pulse while busy
        fill_halt();
        imem[0] = encj(OpLdi, 2'd0, 8'd5);
        imem[1] = encj(OpLdi, 2'd1, 8'd3);
        imem[2] = enc(OpAdd, 2'd2, 2'd0, 2'd1);
        run_prog(20, 1'b1);
        check("t1_r2", 32'(rf[2]), 32'h08);
        check("t1_r7", 32'(rf[7]), 32'h00);

        // carry out of ADD, then JC taken to 0x20
        fill_halt();
        imem[0] = encj(OpLdi, 2'd0, 8'hFF);
        imem[1] = encj(OpLdi, 2'd1, 8'h01);
        imem[2] = enc(OpAdd, 2'd2, 2'd0, 2'd1);
        imem[3] = encj(OpJc, 2'd0, 8'h20);
        imem[4] = encj(OpLdi, 2'd3, 8'h77);
        run_prog(20, 1'b0);
        check("t2_r2", 32'(rf[2]), 32'h00);
        check("t2_r7", 32'(rf[7]), 32'hC0);

        // DEC loop closed by JNZ, then JZ taken over a poison LDI
        fill_halt();
        imem[0] = encj(OpLdi, 2'd0, 8'd3);
        imem[1] = enc(OpDec, 2'd0, 2'd0, 2'd0);
        imem[2] = encj(OpJnz, 2'd0, 8'd1);
        imem[3] = encj(OpJz, 2'd0, 8'd5);
        imem[4] = encj(OpLdi, 2'd1, 8'hEE);
        run_prog(30, 1'b0);
        check("t3_r0", 32'(rf[0]), 32'h00);
        check("t3_r7", 32'(rf[7]), 32'h40);

        // JMP to 0xFF, LDI there, pc wraps to 0 (loop is cut by reset)
        fill_halt();
        imem[0]   = encj(OpJmp, 2'd0, 8'hFF);
        imem[255] = encj(OpLdi, 2'd1, 8'd9);
        run_prog(3, 1'b0);
        check("t4_r1", 32'(rf[1]), 32'h09);

        // reset during EXEC of an ADD: no write may follow
        fill_halt();
        imem[0] = encj(OpLdi, 2'd0, 8'h11);
        imem[1] = encj(OpLdi, 2'd1, 8'h22);
        imem[2] = enc(OpAdd, 2'd2, 2'd0, 2'd1);
        model_run(2);
        base = done_cnt;
        pulse_start();
        wait_retire(base, 2, budget);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0; wbase = wr_cnt;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_no_write", 32'(wr_cnt - wbase), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_pc", 32'(pc), 32'd0);
        check("t5_halted", 32'(halted), 32'd0);
        end_checks();

        // randomized programs; jumps may loop, bounded by the instruction limit
        for (int t = 0; t < 10; t++) begin
            fill_halt();
            for (int i = 0; i < 4; i++) imem[i] = encj(OpLdi, 2'(i), 8'($urandom));
            for (int i = 4; i < 17; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == OpJz || op == OpJc || op == OpJnz || op == OpJmp)
                    imem[i] = encj(op, 2'($urandom), 8'($urandom_range(0, 20)));
                else if (op == OpLdi)
                    imem[i] = encj(op, 2'($urandom), 8'($urandom));
                else
                    imem[i] = enc(op, 2'($urandom), 2'($urandom), 2'($urandom));
            end
            run_prog(40, t[0]);
        end

        check("no_rd_wr_overlap", 32'(conflict_cnt), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
